seg_readback: RTL and testbench
===============================

# seg_readback

Seven-segment display readback monitor: the receive end of the board's multiplexed display bus. It samples the active-low anode and segment lines that drive the on-board display and waits for each digit's pattern to settle. It decodes each settled pattern back to a hex nibble and publishes a complete multi-digit value once every digit has been seen. It sits beside the display scanner so the processor's displayed output can be checked in-system and by the bench without a camera.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (1–8).
- STABLE_CYCLES, 16, consecutive unchanged samples required before a digit is captured (≥2).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- an  input  NUM_DIGITS  anode enables, active-low; bit i selects digit i (digit 0 = least-significant nibble).
- seg  input  7  segment lines, active-low, seg[6]=a … seg[0]=g.
- err_clr  input  1  synchronous clear of the sticky error flags.
- value  output  4*NUM_DIGITS  last complete decoded frame; nibble i = digit i.
- digit_valid  output  NUM_DIGITS  bit i set if digit i's pattern was legal in that frame.
- frame_done  output  1  one-cycle pulse when value/digit_valid update.
- pattern_err  output  1  sticky: an illegal pattern was captured.
- bus_err  output  1  sticky: a settled bus had more than one anode low.

## Operation
- Decode table (seg[6:0] → nibble): 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9, 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F. Any other pattern, including blank 1111111, is illegal: nibble 0, valid bit 0, pattern_err set.
- Sampling register smp holds {an,seg} from the previous edge. Stability counter cnt is $clog2(STABLE_CYCLES+1) bits wide.
- Each edge: if {an,seg} differs from smp, cnt←0. Otherwise cnt increments, saturating at STABLE_CYCLES. smp←{an,seg}.
- Capture fires once per steady interval, on the edge where cnt goes STABLE_CYCLES-1→STABLE_CYCLES.
- On capture, with exactly one anode low (digit i): shadow nibble i and shadow valid bit i are written, and mask bit i is set. Recapture of an already-masked digit overwrites its shadow.
- On capture with no anode low: ignored.
- On capture with more than one anode low: ignored, and bus_err is set.
- When mask is all ones: value←shadow, digit_valid←shadow valid, frame_done pulses, mask←0.
- err_clr clears both sticky flags. If an error set event and err_clr occur on the same edge, set wins.

## Timing
- Reset (async assert, values held until release): value=0, digit_valid=0, frame_done=0, pattern_err=0, bus_err=0, mask=0, cnt=0, smp=all ones.
- A bus change first observed at edge 0 is captured at edge STABLE_CYCLES, so the bus must be held across STABLE_CYCLES+1 edges.
- Shadow and mask update at the capture edge. frame_done, value and digit_valid update at the next edge, so latency is 1 cycle from the final capture.
- pattern_err and bus_err assert at the capture edge.
- A change of one cycle's duration restarts the count; no partial capture is possible.
- Reset asserted mid-frame discards the shadow contents and mask; no frame_done is produced for that partial frame.
- frame_done is never asserted on two consecutive cycles, because each capture needs at least STABLE_CYCLES ≥ 2 edges.

## Test plan
- STABLE_CYCLES=4, NUM_DIGITS=4: scan 1,2,3,4 (an=1110,1101,1011,0111), each held 5 cycles → one frame_done; value=16'h4321; digit_valid=4'hF.
- Digit held only 4 cycles (STABLE_CYCLES=4) → no capture, mask unchanged, no frame_done. Extending the hold to 5 cycles → capture.
- Digit 2 shows 1111111 in an otherwise legal scan of A,b,C,d → value=16'hd0bA, digit_valid=4'b1011, pattern_err=1. err_clr then clears it.
- an=1100 held 10 cycles → bus_err=1, no mask change. Frame completes normally afterward.
- Glitch one cycle to a different seg mid-hold → counter restarts; capture occurs STABLE_CYCLES cycles after the glitch ends.
- rst_n low after 3 of 4 digits captured, then a full scan → single frame_done with only the post-reset digits; all outputs 0 during reset.

Source files
------------

// File: rtl/seg_readback.sv
// seg_readback: decodes settled multiplexed seven-segment bus patterns back into a multi-digit hex value
module seg_readback #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [6:0]              seg,
   input  logic                    err_clr,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    frame_done,
   output logic                    pattern_err,
   output logic                    bus_err
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int BW = NUM_DIGITS + 7;
   logic [BW-1:0]           smp;
   logic [CW-1:0]           cnt;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [NUM_DIGITS-1:0]   shv;
   logic [NUM_DIGITS-1:0]   mask;
   logic [NUM_DIGITS-1:0]   sel;
   logic [3:0]              nib;
   logic                    ok;
   logic                    same;
   logic                    cap;
   logic                    one_low;
   logic                    multi;
   logic                    full;
   assign sel     = ~an;
   assign same    = ({an, seg} == smp);
   assign cap     = same && (cnt == CW'(STABLE_CYCLES - 1));
   assign one_low = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   assign multi   = (sel != '0) && !one_low;
   assign full    = &mask;
   // map an active-low segment pattern back to its hex nibble; anything else is illegal
   always_comb begin
      nib = 4'h0;
      ok  = 1'b1;
      case (seg)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0000100: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b1100000: nib = 4'hB;
         7'b0110001: nib = 4'hC;
         7'b1000010: nib = 4'hD;
         7'b0110000: nib = 4'hE;
         7'b0111000: nib = 4'hF;
         default:    ok  = 1'b0;
      endcase
   end
   // track how long the bus has held still; any change restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp <= '1;
         cnt <= '0;
      end else begin
         smp <= {an, seg};
         if (!same) cnt <= '0;
         else if (cnt != CW'(STABLE_CYCLES)) cnt <= cnt + 1'b1;
      end
   end
   // collect captured digits into the shadow frame until every digit has been seen
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         shv    <= '0;
         mask   <= '0;
      end else begin
         if (full) mask <= '0;
         else if (cap && one_low) mask <= mask | sel;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap && one_low && sel[i]) begin
               shadow[4*i +: 4] <= nib;
               shv[i]           <= ok;
            end
         end
      end
   end
   // publish the completed frame one cycle after its last digit is captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value       <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= full;
         if (full) begin
            value       <= shadow;
            digit_valid <= shv;
         end
      end
   end
   // sticky error flags; a new error on the clearing edge keeps the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern_err <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         pattern_err <= (cap && one_low && !ok) || (pattern_err && !err_clr);
         bus_err     <= (cap && multi) || (bus_err && !err_clr);
      end
   end
endmodule

// File: tb/tb_seg_readback.sv
// tb_seg_readback: directed scans of the display bus with a frame scoreboard
module tb_seg_readback;
   localparam int ND = 4;
   localparam int SC = 4;
   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  dv;
   } exp_t;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [ND-1:0] an = '1;
   logic [6:0]    seg = 7'h7F;
   logic          err_clr = 1'b0;
   logic [4*ND-1:0] value;
   logic [ND-1:0] digit_valid;
   logic          frame_done;
   logic          pattern_err;
   logic          bus_err;
   logic [6:0]    pat [16];
   exp_t          q [$];
   int            checks = 0;
   int            errors = 0;
   seg_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .err_clr(err_clr),
      .value(value), .digit_valid(digit_valid), .frame_done(frame_done),
      .pattern_err(pattern_err), .bus_err(bus_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic show(input logic [ND-1:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic dig(input int d, input int h, input int n);
      logic [ND-1:0] a;
      a = ~(4'b0001 << d);
      show(a, pat[h], n);
   endtask
   task automatic idle(input int n);
      show('1, 7'h7F, n);
   endtask
   task automatic expect_frame(input logic [15:0] v, input logic [3:0] dv);
      exp_t e;
      e.v  = v;
      e.dv = dv;
      q.push_back(e);
   endtask
   always @(negedge clk) begin
      if (rst_n && frame_done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: value %0h with no frame expected", value);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("frame_value", 32'(value), 32'(e.v));
            chk("frame_digit_valid", 32'(digit_valid), 32'(e.dv));
         end
      end
   end
   initial begin
      pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_value", 32'(value), 0);
      chk("reset_digit_valid", 32'(digit_valid), 0);
      chk("reset_frame_done", 32'(frame_done), 0);
      chk("reset_pattern_err", 32'(pattern_err), 0);
      chk("reset_bus_err", 32'(bus_err), 0);
      rst_n = 1'b1;
      expect_frame(16'h4321, 4'hF);
      for (int d = 0; d < 4; d++) dig(d, d + 1, 5);
      idle(2);
      dig(0, 1, 4);
      dig(1, 2, 5);
      dig(2, 3, 5);
      dig(3, 4, 5);
      idle(3);
      expect_frame(16'h4325, 4'hF);
      dig(0, 5, 5);
      idle(2);
      expect_frame(16'hD0BA, 4'b1011);
      dig(0, 10, 5);
      dig(1, 11, 5);
      show(4'b1011, 7'h7F, 5);
      dig(3, 13, 5);
      idle(2);
      chk("pattern_err_set", 32'(pattern_err), 1);
      chk("bus_err_quiet", 32'(bus_err), 0);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk("pattern_err_clr", 32'(pattern_err), 0);
      dig(2, 7, 5);
      dig(3, 8, 5);
      show(4'b1100, pat[8], 10);
      chk("bus_err_set", 32'(bus_err), 1);
      chk("pattern_err_quiet", 32'(pattern_err), 0);
      idle(3);
      expect_frame(16'h8765, 4'hF);
      dig(0, 5, 5);
      dig(1, 6, 5);
      idle(2);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      chk("bus_err_clr", 32'(bus_err), 0);
      dig(1, 1, 5);
      dig(2, 2, 5);
      dig(3, 3, 5);
      dig(0, 9, 3);
      dig(0, 1, 1);
      dig(0, 9, 4);
      idle(2);
      expect_frame(16'h3219, 4'hF);
      dig(0, 9, 5);
      idle(2);
      dig(0, 12, 5);
      dig(1, 13, 5);
      dig(2, 14, 5);
      rst_n = 1'b0;
      idle(2);
      chk("midreset_value", 32'(value), 0);
      chk("midreset_digit_valid", 32'(digit_valid), 0);
      chk("midreset_frame_done", 32'(frame_done), 0);
      rst_n = 1'b1;
      dig(3, 15, 5);
      idle(3);
      expect_frame(16'hFEDC, 4'hF);
      for (int d = 0; d < 4; d++) dig(d, d + 12, 5);
      idle(5);
      chk("frames_outstanding", 32'(q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
